// File: rtl/intra_mode_decision.sv
`default_nettype none
// ============================================================================
//  Module   : intra_mode_decision
//  Purpose  : Picks the lowest-SAD intra mode for one 4x4 block. The original
//             block is latched on start, then one predicted block per mode
//             beat is compared against it through a capture / abs-diff /
//             adder-tree pipeline feeding a strict less-than compare.
//  Revision : 1.0  initial release
// ============================================================================
module intra_mode_decision #(
    parameter int NUM_MODES = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] org_blk,
    input  logic [0:127] pre_sam,
    input  logic         pre_valid,
    output logic         busy,
    output logic         done,
    output logic [5:0]   best_mode,
    output logic [11:0]  best_sad
);

    // Register stages between capture and compare (abs-diff, adder tree).
    localparam int         PIPE_DEPTH  = 2;
    localparam logic [5:0] c_last_mode = 6'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FLUSH   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    logic [5:0]          r_cnt;
    logic [0:127]        r_org;
    logic [PIPE_DEPTH:0] r_vld;                  // [0] capture, [1] abs-diff, [2] sum
    logic [5:0]          r_tag [0:PIPE_DEPTH];
    logic [0:127]        r_cap_pre;
    logic [7:0]          r_s1_diff [0:15];
    logic [11:0]         r_s2_sum;

    logic [7:0]          w_absdiff [0:15];
    logic [11:0]         w_sum;
    logic                w_beat;
    logic                w_drained;

    assign w_beat    = (r_state == S_COLLECT) && pre_valid;
    // Everything ahead of the sum stage is empty, so the sum stage retires
    // its last entry on this edge and the result is final after it.
    assign w_drained = ~|r_vld[PIPE_DEPTH-1:0];

    // Per-pixel magnitude of the 9-bit signed difference.
    for (genvar i = 0; i < 16; i++) begin : g_absdiff
        logic [8:0] w_delta;
        logic [8:0] w_neg;
        assign w_delta      = {1'b0, r_org[i*8 +: 8]} - {1'b0, r_cap_pre[i*8 +: 8]};
        assign w_neg        = 9'd0 - w_delta;
        assign w_absdiff[i] = w_delta[8] ? w_neg[7:0] : w_delta[7:0];
    end

    // Sum of the 16 registered differences; max 4080 fits in 12 bits.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 16; i++) begin
            w_sum = w_sum + {4'd0, r_s1_diff[i]};
        end
    end

    // Beat capture, abs-diff and sum pipeline with its valid/tag shift chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld     <= '0;
            r_cap_pre <= '0;
            r_s2_sum  <= '0;
            for (int i = 0; i <= PIPE_DEPTH; i++) r_tag[i] <= '0;
            for (int i = 0; i < 16; i++) r_s1_diff[i] <= '0;
        end else begin
            r_vld <= {r_vld[PIPE_DEPTH-1:0], w_beat};
            if (w_beat) begin
                r_cap_pre <= pre_sam;
                r_tag[0]  <= r_cnt;
            end
            for (int i = 1; i <= PIPE_DEPTH; i++) r_tag[i] <= r_tag[i-1];
            for (int i = 0; i < 16; i++) r_s1_diff[i] <= w_absdiff[i];
            r_s2_sum <= w_sum;
        end
    end

    // Control FSM, beat counter, org latch and best-cost tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_org     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            best_mode <= '0;
            best_sad  <= 12'hFFF;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_org    <= org_blk;
                        r_cnt    <= '0;
                        best_sad <= 12'hFFF;
                        busy     <= 1'b1;
                        r_state  <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (pre_valid) begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == c_last_mode) r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_drained) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            // Strict compare: ties keep the earlier (lower) mode ID.
            if ((r_state == S_COLLECT || r_state == S_FLUSH) &&
                r_vld[PIPE_DEPTH] && (r_s2_sum < best_sad)) begin
                best_sad  <= r_s2_sum;
                best_mode <= r_tag[PIPE_DEPTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_intra_mode_decision.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_intra_mode_decision
//  Purpose  : Directed self-checking bench for intra_mode_decision.
//  Revision : 1.0  initial release
// ============================================================================
module tb_intra_mode_decision;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [0:127] org_blk;
    logic [0:127] pre_sam;
    logic         pre_valid;
    logic         busy;
    logic         done;
    logic [5:0]   best_mode;
    logic [11:0]  best_sad;

    int n_cmp    = 0;
    int n_err    = 0;
    int done_cnt = 0;

    intra_mode_decision #(.NUM_MODES(35)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .org_blk   (org_blk),
        .pre_sam   (pre_sam),
        .pre_valid (pre_valid),
        .busy      (busy),
        .done      (done),
        .best_mode (best_mode),
        .best_sad  (best_sad)
    );

    always #5 clk = ~clk;

    // Count every done pulse observed mid-cycle.
    always @(negedge clk) if (rst && done) done_cnt++;

    function automatic logic [0:127] fill(input logic [7:0] b);
        fill = {16{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [0:127] org);
        org_blk = org;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic send_beat(input logic [0:127] d);
        pre_sam   = d;
        pre_valid = 1'b1;
        tick();
        pre_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; pre_valid = 1'b0;
        org_blk = '0; pre_sam = '0;
        repeat (3) tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (best_mode !== 6'd0) begin n_err++; $display("FAIL reset_mode: got %0d expected 0", best_mode); end
        n_cmp++; if (best_sad !== 12'hFFF) begin n_err++; $display("FAIL reset_sad: got %0d expected 4095", best_sad); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_ramp();
        int  base;
        bit  ok;
        bit  busy_drop;
        base = done_cnt;
        busy_drop = 1'b0;
        do_start(fill(8'd0));
        for (int k = 0; k < 35; k++) begin
            if (busy !== 1'b1) busy_drop = 1'b1;
            send_beat(fill(8'(k)));
        end
        n_cmp++; if (busy_drop) begin n_err++; $display("FAIL ramp_busy_high: got dropped expected held"); end
        wait_done(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL ramp_done_timeout: got none expected pulse"); end
        n_cmp++; if (best_mode !== 6'd0) begin n_err++; $display("FAIL ramp_mode: got %0d expected 0", best_mode); end
        n_cmp++; if (best_sad !== 12'd0) begin n_err++; $display("FAIL ramp_sad: got %0d expected 0", best_sad); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ramp_busy_fall: got %b expected 0", busy); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL ramp_done_width: got %b expected 0", done); end
        repeat (3) tick();
        n_cmp++; if (done_cnt !== base + 1) begin n_err++; $display("FAIL ramp_done_count: got %0d expected %0d", done_cnt - base, 1); end
        n_cmp++; if (best_sad !== 12'd0) begin n_err++; $display("FAIL ramp_hold: got %0d expected 0", best_sad); end
    endtask

    task automatic test_single_match();
        bit ok;
        do_start(fill(8'd100));
        for (int k = 0; k < 35; k++) send_beat((k == 17) ? fill(8'd100) : fill(8'd90));
        wait_done(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL match_done_timeout: got none expected pulse"); end
        n_cmp++; if (best_mode !== 6'd17) begin n_err++; $display("FAIL match_mode: got %0d expected 17", best_mode); end
        n_cmp++; if (best_sad !== 12'd0) begin n_err++; $display("FAIL match_sad: got %0d expected 0", best_sad); end
        repeat (2) tick();
    endtask

    task automatic test_tie_max();
        bit ok;
        do_start(fill(8'd0));
        for (int k = 0; k < 35; k++) send_beat(fill(8'hFF));
        wait_done(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL tie_done_timeout: got none expected pulse"); end
        n_cmp++; if (best_mode !== 6'd0) begin n_err++; $display("FAIL tie_mode: got %0d expected 0", best_mode); end
        n_cmp++; if (best_sad !== 12'd4080) begin n_err++; $display("FAIL tie_sad: got %0d expected 4080", best_sad); end
        repeat (2) tick();
    endtask

    task automatic test_gapped_latency();
        do_start(fill(8'd50));
        for (int k = 0; k < 35; k++) begin
            send_beat(fill(8'(50 + 34 - k)));
            if (k != 34) tick();
        end
        // Edge T (capture of beat 34) has just passed.
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL gap_done_t1: got %b expected 0", done); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL gap_done_t2: got %b expected 0", done); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL gap_done_t3: got %b expected 1", done); end
        n_cmp++; if (best_mode !== 6'd34) begin n_err++; $display("FAIL gap_mode: got %0d expected 34", best_mode); end
        n_cmp++; if (best_sad !== 12'd0) begin n_err++; $display("FAIL gap_sad: got %0d expected 0", best_sad); end
        repeat (2) tick();
    endtask

    task automatic test_idle_boundary();
        bit ok;
        org_blk   = fill(8'd0);
        pre_sam   = fill(8'd0);
        pre_valid = 1'b1;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start     = 1'b0;
        pre_valid = 1'b0;
        for (int k = 0; k < 35; k++) send_beat((k == 34) ? fill(8'd1) : fill(8'd5));
        wait_done(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL idle_done_timeout: got none expected pulse"); end
        n_cmp++; if (best_mode !== 6'd34) begin n_err++; $display("FAIL idle_mode: got %0d expected 34", best_mode); end
        n_cmp++; if (best_sad !== 12'd16) begin n_err++; $display("FAIL idle_sad: got %0d expected 16", best_sad); end
        repeat (2) tick();
    endtask

    task automatic test_mid_reset();
        int base;
        bit ok;
        base = done_cnt;
        do_start(fill(8'd0));
        for (int k = 0; k <= 10; k++) send_beat(fill(8'(k + 1)));
        rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_cmp++; if (best_sad !== 12'hFFF) begin n_err++; $display("FAIL rstmid_sad: got %0d expected 4095", best_sad); end
        tick();
        rst = 1'b1;
        repeat (10) tick();
        n_cmp++; if (done_cnt !== base) begin n_err++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt - base); end
        do_start(fill(8'd0));
        for (int k = 0; k < 35; k++) send_beat((k == 5) ? fill(8'd3) : fill(8'd200));
        wait_done(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_done_timeout: got none expected pulse"); end
        n_cmp++; if (best_mode !== 6'd5) begin n_err++; $display("FAIL rstmid_mode: got %0d expected 5", best_mode); end
        n_cmp++; if (best_sad !== 12'd48) begin n_err++; $display("FAIL rstmid_sad2: got %0d expected 48", best_sad); end
        repeat (2) tick();
    endtask

    task automatic test_start_while_busy();
        bit ok;
        do_start(fill(8'd10));
        for (int k = 0; k < 35; k++) begin
            if (k == 8) begin
                org_blk = fill(8'd200);
                start   = 1'b1;
                tick();
                start   = 1'b0;
            end
            send_beat((k == 20) ? fill(8'd10) : fill(8'd200));
        end
        wait_done(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL busystart_done_timeout: got none expected pulse"); end
        n_cmp++; if (best_mode !== 6'd20) begin n_err++; $display("FAIL busystart_mode: got %0d expected 20", best_mode); end
        n_cmp++; if (best_sad !== 12'd0) begin n_err++; $display("FAIL busystart_sad: got %0d expected 0", best_sad); end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_single_match();
        test_tie_max();
        test_gapped_latency();
        test_idle_boundary();
        test_mid_reset();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/intra_mode_decision.md
Name: intra_mode_decision

Overview:
- Consumer end of the 4x4 intra prediction sample stream.
- Latches the original 4x4 block, then accepts one predicted block per mode beat (modes 0..NUM_MODES-1 in order).
- Computes SAD of each predicted block against the original and reports the lowest-cost mode and its SAD.
- Sits between the prediction sample generator and the mode/residual control logic.

Parameters:
- NUM_MODES, 35, number of prediction beats per block (mode IDs 0..NUM_MODES-1, fixed arrival order).
- PIPE_DEPTH, 2, register stages between beat capture and compare (abs-diff stage, adder-tree stage). Fixed; not user-tunable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; latches org_blk and begins a new block (honoured in IDLE only)
- org_blk  input  128  original samples; pixel i (raster, row-major, i=0 top-left) at bits [i*8 +: 8], vector indexed [0:127]
- pre_sam  input  128  predicted samples, same packing as org_blk
- pre_valid  input  1  pre_sam carries the next mode's prediction this cycle
- busy  output  1  high from the accepted start until done
- done  output  1  one-cycle pulse; best_mode/best_sad are final
- best_mode  output  6  winning mode ID
- best_sad  output  12  winning SAD (max 16*255 = 4080)

Behaviour:
- Reset (rst low, async): state=IDLE; busy=0, done=0, best_mode=0, best_sad=12'hFFF; beat counter, pipeline valids and the latched org block cleared.
- FSM states and transitions:
  - IDLE: on start=1, latch org_blk, clear beat counter, set best_sad=12'hFFF, go to COLLECT. pre_valid is ignored.
  - COLLECT: each cycle with pre_valid=1 is one beat, tagged with the beat counter value (mode ID), after which the counter increments. After beat NUM_MODES-1 is accepted, go to FLUSH. Gaps in pre_valid are allowed. start is ignored.
  - FLUSH: no beats accepted (pre_valid ignored). Stay until both pipeline stages are empty, then go to DONE.
  - DONE: done=1 for exactly one cycle; busy falls in the same cycle. Next state is IDLE.
- Pipeline:
  - Stage 1 (edge after beat): 16 registered absolute differences |org-pre|, 8b each, plus the mode tag.
  - Stage 2 (next edge): 12-bit sum of the 16 differences, plus the mode tag.
  - Compare (next edge): if sad < best_sad (strict), update best_sad and best_mode. Ties therefore keep the lower mode ID.
- Latency:
  - A beat captured at edge T updates best_* at edge T+3.
  - For the final beat captured at edge T, done is high in the cycle following edge T+3.
- Arithmetic: all values unsigned. The abs-diff is computed at 9-bit width before magnitude. The sum cannot overflow 12 bits.
- best_mode/best_sad:
  - Change only during COLLECT/FLUSH.
  - Hold their values after done until the next accepted start.
- Boundaries:
  - start and pre_valid in the same IDLE cycle: start is accepted, that pre_valid is dropped.
  - pre_valid while in IDLE, FLUSH or DONE: ignored; no counter change.
  - Reset mid-block: all state is lost; no done is issued; a new start is required.
  - start while busy: ignored; the latched org_blk is unchanged.

Test Plan:
- org=all 0x00; beat k = all bytes k (k=0..34) -> best_mode=0, best_sad=0, one done pulse, busy high start..done.
- org=all 100; beat 17 = all 100, other beats all 90 -> best_mode=17, best_sad=0.
- org=all 0; all 35 beats all 0xFF -> tie on every beat; best_mode=0, best_sad=4080.
- org=all 50; beats k=all (50+(34-k)) with pre_valid toggling 1/0 each cycle -> best_mode=34, best_sad=0; done exactly 3 cycles after the edge capturing beat 34.
- Assert rst low after beat 10 of a block -> busy=0, best_sad=0xFFF, no done pulse; a fresh start then completes normally.
- Pulse start during COLLECT with a different org_blk -> ignored; result matches the originally latched org.
